// File: rtl/ex_muldiv_pkg.sv
// Shared constants, state encoding and sign helper for the EX-stage RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int ITER_COUNT = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side request and EX-side result bundle of the multiply/divide unit.
interface ex_muldiv_if;
    import muldiv_pkg::*;

    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_addr_o;

    modport master (
        output start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
        input  busy_o, valid_o, result_o, rd_addr_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
        output busy_o, valid_o, result_o, rd_addr_o
    );

endinterface

// File: rtl/ex_muldiv_div_iter.sv
// Restoring radix-2 divider datapath on unsigned magnitudes: one quotient bit per step.
module muldiv_div_iter
    import muldiv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN+1:0] shift_s, diff_s;

    // Quotient register doubles as the dividend shifter; a non-negative trial difference sets the bit.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        shift_s = {rem_q, quo_q[XLEN-1]};
        diff_s  = shift_s - {2'b00, dvs_q};
        if (start_i) begin
            rem_d = {(XLEN+1){1'b0}};
            quo_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = 5'(ITER_COUNT - 1);
        end else if (step_i) begin
            rem_d = diff_s[XLEN+1] ? shift_s[XLEN:0] : diff_s[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], ~diff_s[XLEN+1]};
            cnt_d = (cnt_q != 5'd0) ? (cnt_q - 5'd1) : cnt_q;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Iteration state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rem_q <= {(XLEN+1){1'b0}};
            quo_q <= {XLEN{1'b0}};
            dvs_q <= {XLEN{1'b0}};
            cnt_q <= 5'd0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o      = (cnt_q == 5'd0);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit in EX: single-cycle multiply, 34-cycle divide, stalls via busy_o.
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    ex_muldiv_if.slave bus
);

    state_e          state_q, state_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d, rd_q, rd_d;
    logic            op_rem_q, op_rem_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;

    logic            div_signed_s, a_neg_s, b_neg_s, div_zero_s, div_ovf_s, fast_op_s;
    logic            a_ext_s, b_ext_s;
    logic [XLEN-1:0] abs_a_s, abs_b_s, fast_res_s, fix_res_s, quo_s, rem_s;
    logic [63:0]     mul_a_s, mul_b_s, mul_p_s;
    logic            div_start_s, div_step_s, div_done_s;

    assign div_signed_s = ~bus.funct3_i[0];
    assign a_neg_s      = div_signed_s & bus.rs1_data_i[XLEN-1];
    assign b_neg_s      = div_signed_s & bus.rs2_data_i[XLEN-1];
    assign abs_a_s      = negate_if(a_neg_s, bus.rs1_data_i);
    assign abs_b_s      = negate_if(b_neg_s, bus.rs2_data_i);
    assign div_zero_s   = (bus.rs2_data_i == 32'h0000_0000);
    assign div_ovf_s    = div_signed_s & (bus.rs1_data_i == 32'h8000_0000)
                        & (bus.rs2_data_i == 32'hFFFF_FFFF);
    assign fast_op_s    = ~bus.funct3_i[2] | div_zero_s | div_ovf_s;

    // Wrap-around 64-bit product of the extended operands gives the exact high word for every variant.
    assign a_ext_s = ((bus.funct3_i == F3_MULH) | (bus.funct3_i == F3_MULHSU)) & bus.rs1_data_i[XLEN-1];
    assign b_ext_s = (bus.funct3_i == F3_MULH) & bus.rs2_data_i[XLEN-1];
    assign mul_a_s = {{32{a_ext_s}}, bus.rs1_data_i};
    assign mul_b_s = {{32{b_ext_s}}, bus.rs2_data_i};
    assign mul_p_s = mul_a_s * mul_b_s;

    // Result of operations that complete on the accepting edge.
    always_comb begin
        fast_res_s = {XLEN{1'b0}};
        case (bus.funct3_i)
            F3_MUL:                       fast_res_s = mul_p_s[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fast_res_s = mul_p_s[63:32];
            default: begin
                if (div_zero_s) begin
                    fast_res_s = bus.funct3_i[1] ? bus.rs1_data_i : 32'hFFFF_FFFF;
                end else begin
                    fast_res_s = bus.funct3_i[1] ? 32'h0000_0000 : 32'h8000_0000;
                end
            end
        endcase
    end

    // Sign restoration of the magnitude result.
    always_comb begin
        if (op_rem_q) begin
            fix_res_s = negate_if(r_neg_q, rem_s);
        end else begin
            fix_res_s = negate_if(q_neg_q, quo_s);
        end
    end

    muldiv_div_iter u_div_iter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start_s),
        .step_i      (div_step_s),
        .dividend_i  (abs_a_s),
        .divisor_i   (abs_b_s),
        .done_o      (div_done_s),
        .quotient_o  (quo_s),
        .remainder_o (rem_s)
    );

    // FSM next state and output-register updates; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        valid_d     = 1'b0;
        result_d    = result_q;
        rd_out_d    = rd_out_q;
        rd_d        = rd_q;
        op_rem_d    = op_rem_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        div_start_s = 1'b0;
        div_step_s  = 1'b0;
        if (bus.flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        rd_d     = bus.rd_addr_i;
                        op_rem_d = bus.funct3_i[1];
                        q_neg_d  = a_neg_s ^ b_neg_s;
                        r_neg_d  = a_neg_s;
                        if (fast_op_s) begin
                            state_d  = S_DONE;
                            valid_d  = 1'b1;
                            result_d = fast_res_s;
                            rd_out_d = bus.rd_addr_i;
                        end else begin
                            state_d     = S_DIV;
                            div_start_s = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DIV: begin
                    div_step_s = 1'b1;
                    state_d    = div_done_s ? S_FIX : S_DIV;
                end
                S_FIX: begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    result_d = fix_res_s;
                    rd_out_d = rd_q;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM, latched operation attributes and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            result_q <= {XLEN{1'b0}};
            rd_out_q <= 5'd0;
            rd_q     <= 5'd0;
            op_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            rd_q     <= rd_d;
            op_rem_q <= op_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
        end
    end

    assign bus.busy_o    = rst_i & ~bus.flush_i
                         & (((state_q == S_IDLE) & bus.start_i) | (state_q == S_DIV) | (state_q == S_FIX));
    assign bus.valid_o   = valid_q;
    assign bus.result_o  = result_q;
    assign bus.rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed plan vectors plus random ops against an arithmetic model.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    ex_muldiv_if bus_if ();

    ex_muldiv dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] up;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Multiplies and special-case divides take 1 edge; other divides take 34.
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 < 3'd4) return 1;
        if (b == 32'd0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input string tag);
        int exp_lat, edges, busy_cnt;
        bit got;
        exp_lat = ref_latency(f3, a, b);
        @(negedge clk); #1;
        bus_if.start_i = 1'b1; bus_if.funct3_i = f3;
        bus_if.rs1_data_i = a; bus_if.rs2_data_i = b; bus_if.rd_addr_i = rd;
        #1;
        busy_cnt = (bus_if.busy_o === 1'b1) ? 1 : 0;
        edges = 0; got = 1'b0;
        while (!got && edges < 60) begin
            @(negedge clk); #2;
            edges++;
            if (bus_if.valid_o === 1'b1) got = 1'b1;
            else if (bus_if.busy_o === 1'b1) busy_cnt++;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s timeout: no valid_o after %0d edges, required %0d", tag, edges, exp_lat);
        end else begin
            checks++;
            if (bus_if.result_o !== exp_res) begin
                failures++;
                $display("FAIL %s result: got %h expected %h", tag, bus_if.result_o, exp_res);
            end
            checks++;
            if (bus_if.rd_addr_o !== rd) begin
                failures++;
                $display("FAIL %s rd: got %0d expected %0d", tag, bus_if.rd_addr_o, rd);
            end
            checks++;
            if (edges != exp_lat) begin
                failures++;
                $display("FAIL %s latency: got %0d expected %0d", tag, edges, exp_lat);
            end
            checks++;
            if (busy_cnt != exp_lat) begin
                failures++;
                $display("FAIL %s busy cycles: got %0d expected %0d", tag, busy_cnt, exp_lat);
            end
            checks++;
            if (bus_if.busy_o !== 1'b0) begin
                failures++;
                $display("FAIL %s busy in done: got %b expected 0", tag, bus_if.busy_o);
            end
        end
        bus_if.start_i = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (bus_if.valid_o !== 1'b0 || bus_if.result_o !== exp_res) begin
            failures++;
            $display("FAIL %s pulse/hold: valid %b result %h expected valid 0 result %h",
                     tag, bus_if.valid_o, bus_if.result_o, exp_res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.start_i = 1'b1; bus_if.funct3_i = F3_MUL;
        bus_if.rs1_data_i = 32'd6; bus_if.rs2_data_i = 32'd7; bus_if.rd_addr_i = 5'd3;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (bus_if.valid_o !== 1'b0 || bus_if.result_o !== 32'd0 || bus_if.rd_addr_o !== 5'd0 || bus_if.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset state: valid %b result %h rd %0d busy %b expected all 0",
                     bus_if.valid_o, bus_if.result_o, bus_if.rd_addr_o, bus_if.busy_o);
        end
        rst_n = 1'b1;
        bus_if.start_i = 1'b0;
        @(negedge clk); #2;
        checks++;
        if (bus_if.valid_o !== 1'b0 || bus_if.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset release: valid %b busy %b expected 0 0", bus_if.valid_o, bus_if.busy_o);
        end
    endtask

    task automatic test_directed();
        run_op(F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, "mul_7x-3");
        run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, "mulhu_ff");
        run_op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000, "mulh_ff");
        run_op(F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, "mulhsu_ff");
        run_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFD, "div_-7_2");
        run_op(F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, "rem_-7_2");
        run_op(F3_DIVU,   32'd5,          32'd0,         5'd7,  32'hFFFF_FFFF, "divu_5_0");
        run_op(F3_REMU,   32'd5,          32'd0,         5'd8,  32'd5,         "remu_5_0");
        run_op(F3_REM,    32'hFFFF_FFFB,  32'd0,         5'd9,  32'hFFFF_FFFB, "rem_-5_0");
        run_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, "div_ovf");
        run_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'd0,         "rem_ovf");
        run_op(F3_DIVU,   32'hFFFF_FFFF,  32'd1,         5'd12, 32'hFFFF_FFFF, "divu_max_1");
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op(f3, a, b, 5'($urandom_range(0, 31)), ref_result(f3, a, b), $sformatf("rand%0d_f%0d", i, f3));
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3s [6];
        logic [31:0] as [6];
        logic [31:0] bs [6];
        int idx, cyc, last;
        for (int i = 0; i < 6; i++) begin
            f3s[i] = 3'($urandom_range(0, 3));
            as[i]  = $urandom;
            bs[i]  = $urandom;
        end
        @(negedge clk); #1;
        bus_if.start_i = 1'b1; bus_if.funct3_i = f3s[0];
        bus_if.rs1_data_i = as[0]; bus_if.rs2_data_i = bs[0]; bus_if.rd_addr_i = 5'd20;
        idx = 0; cyc = 0; last = 0;
        while (idx < 6 && cyc < 100) begin
            @(negedge clk); #2;
            cyc++;
            if (bus_if.valid_o === 1'b1) begin
                checks++;
                if (bus_if.result_o !== ref_result(f3s[idx], as[idx], bs[idx]) || bus_if.rd_addr_o !== 5'(20 + idx)) begin
                    failures++;
                    $display("FAIL b2b%0d result: got %h rd %0d expected %h rd %0d", idx, bus_if.result_o,
                             bus_if.rd_addr_o, ref_result(f3s[idx], as[idx], bs[idx]), 20 + idx);
                end
                checks++;
                if (cyc - last != ((idx == 0) ? 1 : 2)) begin
                    failures++;
                    $display("FAIL b2b%0d spacing: got %0d expected %0d", idx, cyc - last, (idx == 0) ? 1 : 2);
                end
                last = cyc;
                idx++;
                if (idx < 6) begin
                    bus_if.funct3_i = f3s[idx];
                    bus_if.rs1_data_i = as[idx]; bus_if.rs2_data_i = bs[idx]; bus_if.rd_addr_i = 5'(20 + idx);
                end else begin
                    bus_if.start_i = 1'b0;
                end
            end
        end
        bus_if.start_i = 1'b0;
        checks++;
        if (idx != 6) begin
            failures++;
            $display("FAIL b2b count: got %0d results expected 6", idx);
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        int vcnt;
        @(negedge clk); #1;
        prev = bus_if.result_o;
        bus_if.start_i = 1'b1; bus_if.funct3_i = F3_DIV;
        bus_if.rs1_data_i = 32'hFFFF_FFF9; bus_if.rs2_data_i = 32'd2; bus_if.rd_addr_i = 5'd9;
        repeat (11) @(negedge clk);
        #1;
        bus_if.flush_i = 1'b1;
        #1;
        checks++;
        if (bus_if.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush busy comb: got %b expected 0", bus_if.busy_o);
        end
        @(negedge clk); #1;
        bus_if.flush_i = 1'b0;
        bus_if.start_i = 1'b0;
        #1;
        checks++;
        if (bus_if.busy_o !== 1'b0 || bus_if.valid_o !== 1'b0 || bus_if.result_o !== prev) begin
            failures++;
            $display("FAIL flush after: busy %b valid %b result %h expected 0 0 %h",
                     bus_if.busy_o, bus_if.valid_o, bus_if.result_o, prev);
        end
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #2;
            if (bus_if.valid_o === 1'b1) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin
            failures++;
            $display("FAIL flush no result: got %0d valid pulses expected 0", vcnt);
        end
        run_op(F3_MUL, 32'd3, 32'd4, 5'd13, 32'd12, "mul_after_flush");
    endtask

    task automatic test_reset_mid();
        int vcnt;
        @(negedge clk); #1;
        bus_if.start_i = 1'b1; bus_if.funct3_i = F3_DIVU;
        bus_if.rs1_data_i = 32'd100; bus_if.rs2_data_i = 32'd7; bus_if.rd_addr_i = 5'd17;
        repeat (6) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst busy forced: got %b expected 0", bus_if.busy_o);
        end
        @(negedge clk); #1;
        checks++;
        if (bus_if.valid_o !== 1'b0 || bus_if.result_o !== 32'd0 || bus_if.rd_addr_o !== 5'd0 || bus_if.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst mid-div: valid %b result %h rd %0d busy %b expected all 0",
                     bus_if.valid_o, bus_if.result_o, bus_if.rd_addr_o, bus_if.busy_o);
        end
        rst_n = 1'b1;
        bus_if.start_i = 1'b0;
        #1;
        checks++;
        if (bus_if.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst state idle: busy %b expected 0", bus_if.busy_o);
        end
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #2;
            if (bus_if.valid_o === 1'b1) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin
            failures++;
            $display("FAIL rst discards div: got %0d valid pulses expected 0", vcnt);
        end
        run_op(F3_REMU, 32'd100, 32'd7, 5'd18, 32'd2, "remu_after_rst");
    endtask

    initial begin
        bus_if.start_i    = 1'b0;
        bus_if.funct3_i   = 3'd0;
        bus_if.rs1_data_i = 32'd0;
        bus_if.rs2_data_i = 32'd0;
        bus_if.rd_addr_i  = 5'd0;
        bus_if.flush_i    = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the ID/EX operands, funct3 and destination register for M-extension R-type instructions (funct7 = 0000001). It produces one registered result per instruction and holds IF, ID and ID/EX through `busy_o` while an operation is in flight. The ALU and forwarding paths stay untouched; the EX result mux selects `result_o` when `valid_o` is high.

## Interface
- XLEN, 32, operand/result width (only 32 supported)
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- start_i  in  1  ID/EX holds an M-extension instruction (ALUOp R-type and funct7 = 0000001)
- funct3_i  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data_i  in  XLEN  dividend / multiplicand, already forwarded
- rs2_data_i  in  XLEN  divisor / multiplier, already forwarded
- rd_addr_i  in  5  destination register
- flush_i  in  1  kill the in-flight operation (branch/exception)
- busy_o  out  1  stall request to PC, IF/ID and ID/EX
- valid_o  out  1  one-cycle pulse, result_o/rd_addr_o valid
- result_o  out  XLEN  operation result
- rd_addr_o  out  5  destination of result_o

## Operation
- FSM states: IDLE, DIV, FIX, DONE.
- **IDLE:**
  - start_i=1 latches funct3, operands and rd_addr.
  - MUL* and special-case divides go to DONE. The result is computed and registered on the same edge.
  - Any other divide goes to DIV with iteration counter = 31.
- **Multiply:**
  - 64-bit product of sign- or zero-extended operands: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - MUL returns [31:0]; all others return [63:32].
- **Special-case divides:**
  - divisor = 0: quotient = 0xFFFFFFFF, remainder = dividend (signed and unsigned).
  - Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- **DIV:**
  - Restoring radix-2 division on magnitudes. Signed ops use absolute values; unsigned ops use the raw operands.
  - One quotient bit per cycle. The counter decrements each cycle; DIV goes to FIX when the counter = 0 (32 iterations).
  - Partial remainder is 33 bits wide.
- **FIX:**
  - For signed ops, negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Select quotient or remainder, register it into result_o, go to DONE.
- **DONE:**
  - valid_o = 1 for exactly this cycle; go to IDLE.
  - start_i is ignored in DONE (it is still the held instruction).
- **busy_o** (combinational) = (state==IDLE & start_i) | state==DIV | state==FIX. busy_o is low in DONE, so ID/EX advances in the same cycle valid_o is seen.
- **flush_i:** has priority over start_i in every state. On the next edge: state goes to IDLE, valid_o = 0, no result is produced. busy_o goes low combinationally while flush_i = 1.
- **Reset (rst_i = 0 at an edge):** state = IDLE, counter = 0, valid_o = 0, result_o = 0, rd_addr_o = 0. busy_o is forced to 0 while rst_i = 0. Reset mid-DIV discards the operation.
- result_o and rd_addr_o hold their last value outside valid_o.

## Timing
- Edge E0 is the rising edge at which start_i is sampled in IDLE.
- **MUL* / special divide:** busy_o is high in the cycle before E0 (one stall cycle). valid_o is high in the cycle after E0. Latency is 1.
- **Normal divide:**
  - DIV is occupied for cycles E0..E31.
  - FIX is reached at E32; DONE (valid_o high) at E33. Latency is 34 edges and 34 stall cycles in total.
- **Back-to-back:** a new start_i is accepted at the earliest in the cycle after DONE, i.e. the next edge in IDLE. Minimum issue interval is 2 cycles for multiply.
- No combinational path exists from the operands to any output; only busy_o depends combinationally on start_i, flush_i and rst_i.

## Structure
- Package `muldiv_pkg` holds:
  - the funct3 opcode constants (MUL..REMU) and the funct7 M-extension constant 7'b0000001;
  - the state enum {IDLE, DIV, FIX, DONE};
  - the iteration count constant 32.
- One sub-module, `muldiv_div_iter`: the 33-bit partial remainder, quotient shift register and counter, with start/step/done signals.
- Sign handling, the multiply, the special cases, the FSM and the output registers stay in `ex_muldiv`.

## Test plan
- MUL: 7 × 0xFFFFFFFD (−3) → result_o = 0xFFFFFFEB; valid_o one edge after start; busy_o high exactly 1 cycle.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000.
- DIV: −7 / 2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF. valid_o occurs 34 edges after start and busy_o is high for 34 cycles.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, both at latency 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0.
- flush_i asserted at iteration 10 of a DIV → next cycle state IDLE, busy_o = 0, no valid_o pulse. A following MUL 3×4 → 12.
- rst_i low for one edge mid-DIV → all outputs 0, state IDLE. start_i held high during reset is ignored and busy_o stays 0.
